// File: rtl/tpu_wb_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : tpu_wb_ctrl_if
// Brief    : Row-result input stream and output-SRAM write bus of the TPU
//            write-back controller.
// Revision : 1.0 - initial release
// ============================================================================
interface tpu_wb_ctrl_if #(
    parameter int LANES     = 8,
    parameter int ACC_W     = 24,
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = 3,
    parameter int ADDR_W    = 6
);
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*ACC_W-1:0]  in_data;
    logic [NUM_BANKS-1:0]    sram_write_enable;
    logic [LANES*DATA_W-1:0] sram_wdata;
    logic [ADDR_W-1:0]       sram_waddr;

    modport master (
        output in_valid, in_data,
        input  in_ready, sram_write_enable, sram_wdata, sram_waddr
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, sram_write_enable, sram_wdata, sram_waddr
    );
endinterface
`default_nettype wire

// File: rtl/tpu_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tpu_wb_ctrl
// Brief    : Rescales, saturates and packs accumulator rows, then writes them
//            to NUM_BANKS output SRAM banks in sequential or interleaved order.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_wb_ctrl #(
    parameter int LANES     = 8,
    parameter int ACC_W     = 24,
    parameter int DATA_W    = 16,
    parameter int NUM_BANKS = 3,
    parameter int ADDR_W    = 6,
    parameter int CNT_W     = 10
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               start,
    input  logic [CNT_W-1:0]   cfg_rows,
    input  logic [4:0]         cfg_shift,
    input  logic               cfg_interleave,
    tpu_wb_ctrl_if.slave       bus,
    output logic               busy,
    output logic               done,
    output logic               sat_flag
);

    localparam int c_BANK_W  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int c_STATE_W = 2;
    localparam logic [CNT_W-1:0]    c_MAX_ROWS  = CNT_W'(NUM_BANKS * (2 ** ADDR_W));
    localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0]   c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [c_BANK_W-1:0] c_BANK_ONE  = c_BANK_W'(1);
    localparam logic [c_BANK_W-1:0] c_LAST_BANK = c_BANK_W'(NUM_BANKS - 1);
    localparam logic signed [ACC_W:0] c_RND_ONE = {{ACC_W{1'b0}}, 1'b1};
    localparam logic signed [ACC_W:0] c_SAT_MAX = {{(ACC_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_SAT_MIN = {{(ACC_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [c_STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [CNT_W-1:0]        r_rows, r_acc_cnt;
    logic [4:0]              r_shift;
    logic                    r_interleave;
    logic [c_BANK_W-1:0]     r_bank;
    logic [ADDR_W-1:0]       r_addr;
    logic                    r_sat;
    logic [NUM_BANKS-1:0]    r_we;
    logic [LANES*DATA_W-1:0] r_wdata;
    logic [ADDR_W-1:0]       r_waddr;

    logic                    w_in_ready, w_accept, w_last_row;
    logic [CNT_W-1:0]        w_eff_rows, w_acc_nxt;
    logic [NUM_BANKS-1:0]    w_bank_oh;
    logic [LANES*DATA_W-1:0] w_pack;
    logic [LANES-1:0]        w_clamp;

    // Oversized jobs are truncated to the total capacity of all banks.
    assign w_eff_rows = (cfg_rows > c_MAX_ROWS) ? c_MAX_ROWS : cfg_rows;
    assign w_acc_nxt  = r_acc_cnt + c_CNT_ONE;
    assign w_last_row = (w_acc_nxt == r_rows);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            w_bank_oh[b] = (r_bank == c_BANK_W'(b));
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [ACC_W:0] w_ext, w_rnd, w_shf;
        logic [DATA_W-1:0]     w_lane;
        logic                  w_clamp_l;

        always_comb begin
            w_ext     = {bus.in_data[gi*ACC_W+ACC_W-1], bus.in_data[gi*ACC_W +: ACC_W]};
            w_rnd     = w_ext;
            w_shf     = w_ext;
            w_clamp_l = 1'b0;
            if (r_shift != 5'd0) begin
                if (int'(r_shift) >= ACC_W) begin
                    w_shf = w_ext[ACC_W] ? '1 : '0;
                end else begin
                    w_rnd = w_ext + (c_RND_ONE << (r_shift - 5'd1));
                    w_shf = w_rnd >>> r_shift;
                end
            end
            w_lane = w_shf[DATA_W-1:0];
            if (w_shf > c_SAT_MAX) begin
                w_lane    = c_SAT_MAX[DATA_W-1:0];
                w_clamp_l = 1'b1;
            end else if (w_shf < c_SAT_MIN) begin
                w_lane    = c_SAT_MIN[DATA_W-1:0];
                w_clamp_l = 1'b1;
            end
        end

        assign w_pack[gi*DATA_W +: DATA_W] = w_lane;
        assign w_clamp[gi]                 = w_clamp_l;
    end

    always_ff @(posedge clk) begin
        if (srst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) w_state_nxt = (w_eff_rows == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                w_in_ready = (r_acc_cnt < r_rows);
                if (bus.in_valid && w_in_ready && w_last_row) w_state_nxt = S_FLUSH;
            end
            S_FLUSH: w_state_nxt = S_DONE;
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            r_rows       <= '0;
            r_acc_cnt    <= '0;
            r_shift      <= '0;
            r_interleave <= 1'b0;
            r_bank       <= '0;
            r_addr       <= '0;
            r_sat        <= 1'b0;
            r_we         <= '0;
            r_wdata      <= '0;
            r_waddr      <= '0;
        end else begin
            r_we <= '0;
            if (r_state == S_IDLE && start) begin
                r_rows       <= w_eff_rows;
                r_shift      <= cfg_shift;
                r_interleave <= cfg_interleave;
                r_acc_cnt    <= '0;
                r_bank       <= '0;
                r_addr       <= '0;
                r_sat        <= 1'b0;
            end
            if (w_accept) begin
                r_we      <= w_bank_oh;
                r_wdata   <= w_pack;
                r_waddr   <= r_addr;
                r_acc_cnt <= w_acc_nxt;
                if (|w_clamp) r_sat <= 1'b1;
                // Bank/address walk replaces any division by depth or bank count.
                if (r_interleave) begin
                    if (r_bank == c_LAST_BANK) begin
                        r_bank <= '0;
                        r_addr <= r_addr + c_ADDR_ONE;
                    end else begin
                        r_bank <= r_bank + c_BANK_ONE;
                    end
                end else begin
                    if (&r_addr) begin
                        r_addr <= '0;
                        r_bank <= r_bank + c_BANK_ONE;
                    end else begin
                        r_addr <= r_addr + c_ADDR_ONE;
                    end
                end
            end
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.sram_write_enable = r_we;
    assign bus.sram_wdata        = r_wdata;
    assign bus.sram_waddr        = r_waddr;
    assign sat_flag              = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_tpu_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_wb_ctrl
// Brief    : Randomised scoreboard bench for tpu_wb_ctrl with a lane-arithmetic
//            and bank-placement reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_wb_ctrl;

    localparam int c_LANES = 8;
    localparam int c_ACC_W = 24;
    localparam int c_DATA_W = 16;
    localparam int c_NB = 3;
    localparam int c_AW = 6;
    localparam int c_CNT_W = 10;
    localparam int c_W = c_LANES * c_DATA_W;
    localparam int c_IW = c_LANES * c_ACC_W;
    localparam int c_DEPTH = 2 ** c_AW;
    localparam int c_MAXR = c_NB * c_DEPTH;

    typedef struct {
        int           bank;
        int           addr;
        logic [c_W-1:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               srst = 1'b1;
    logic               start = 1'b0;
    logic [c_CNT_W-1:0] cfg_rows = '0;
    logic [4:0]         cfg_shift = '0;
    logic               cfg_interleave = 1'b0;
    logic               busy, done, sat_flag;

    exp_t           sb_q[$];
    int             n_vec = 0;
    int             n_err = 0;
    int             job_writes = 0;
    bit             hit [c_NB][c_DEPTH];
    bit             prev_srst = 1'b1;
    logic [c_W-1:0] last_wd = '0;
    logic [c_AW-1:0] last_wa = '0;

    tpu_wb_ctrl_if #(
        .LANES(c_LANES), .ACC_W(c_ACC_W), .DATA_W(c_DATA_W),
        .NUM_BANKS(c_NB), .ADDR_W(c_AW)
    ) bus ();

    tpu_wb_ctrl #(
        .LANES(c_LANES), .ACC_W(c_ACC_W), .DATA_W(c_DATA_W),
        .NUM_BANKS(c_NB), .ADDR_W(c_AW), .CNT_W(c_CNT_W)
    ) dut (
        .clk(clk), .srst(srst), .start(start), .cfg_rows(cfg_rows),
        .cfg_shift(cfg_shift), .cfg_interleave(cfg_interleave), .bus(bus),
        .busy(busy), .done(done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [c_W-1:0] act, input logic [c_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lane arithmetic: rounded division by 2^s, then clamp to DATA_W.
    function automatic void model_row(input logic [c_IW-1:0] din, input int s,
                                      output logic [c_W-1:0] dout, output bit clamp);
        longint x, y, smax, smin;
        smax = (64'sd1 <<< (c_DATA_W - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (c_DATA_W - 1));
        dout = '0;
        clamp = 1'b0;
        for (int i = 0; i < c_LANES; i++) begin
            x = longint'($signed(din[i*c_ACC_W +: c_ACC_W]));
            if (s == 0)            y = x;
            else if (s >= c_ACC_W) y = (x < 0) ? -64'sd1 : 64'sd0;
            else                   y = (x + (64'sd1 <<< (s - 1))) >>> s;
            if (y > smax) begin
                y = smax;
                clamp = 1'b1;
            end else if (y < smin) begin
                y = smin;
                clamp = 1'b1;
            end
            dout[i*c_DATA_W +: c_DATA_W] = y[c_DATA_W-1:0];
        end
    endfunction

    function automatic logic [c_IW-1:0] gen_row(input int mode, input int r);
        logic [c_IW-1:0]    d;
        logic [c_ACC_W-1:0] pat [4];
        pat[0] = 24'h000018;
        pat[1] = 24'h7FFFFF;
        pat[2] = 24'hFFFFF7;
        pat[3] = 24'h800000;
        d = '0;
        for (int i = 0; i < c_LANES; i++) begin
            case (mode)
                0:       d[i*c_ACC_W +: c_ACC_W] = c_ACC_W'(r * 8 + i);
                2:       d[i*c_ACC_W +: c_ACC_W] = pat[i % 4];
                3:       d[i*c_ACC_W +: c_ACC_W] = c_ACC_W'(int'($urandom_range(65535)) - 32768);
                default: d[i*c_ACC_W +: c_ACC_W] = c_ACC_W'($urandom);
            endcase
        end
        return d;
    endfunction

    function automatic int hit_count();
        int n = 0;
        for (int b = 0; b < c_NB; b++)
            for (int a = 0; a < c_DEPTH; a++)
                n += int'(hit[b][a]);
        return n;
    endfunction

    // Monitor: every strobe must match the oldest accepted row; idle cycles hold.
    always @(negedge clk) begin : mon
        exp_t e;
        if (prev_srst) begin
            last_wd = '0;
            last_wa = '0;
        end
        if (bus.sram_write_enable != '0) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: enable 0x%0h, expected no write", bus.sram_write_enable);
            end else begin
                e = sb_q.pop_front();
                check("write_enable_bank", c_W'(bus.sram_write_enable), c_W'(1) << e.bank);
                check("write_addr", c_W'(bus.sram_waddr), c_W'(e.addr));
                check("write_data", bus.sram_wdata, e.data);
                job_writes++;
            end
            for (int b = 0; b < c_NB; b++)
                if (bus.sram_write_enable[b]) hit[b][bus.sram_waddr] = 1'b1;
            last_wd = bus.sram_wdata;
            last_wa = bus.sram_waddr;
        end else begin
            check("wdata_hold", bus.sram_wdata, last_wd);
            check("waddr_hold", c_W'(bus.sram_waddr), c_W'(last_wa));
        end
        prev_srst = srst;
    end

    task automatic run_job(input int rows, input int shift, input bit inter, input int vpct,
                           input int mode, input int abort_after, input int stray_at);
        int eff, acc, cyc;
        bit v, clamp, stray_done, m_sat;
        logic [c_W-1:0]  d;
        logic [c_IW-1:0] row;
        eff = (rows > c_MAXR) ? c_MAXR : rows;
        m_sat = 1'b0;
        job_writes = 0;
        for (int b = 0; b < c_NB; b++)
            for (int a = 0; a < c_DEPTH; a++)
                hit[b][a] = 1'b0;
        cfg_rows = c_CNT_W'(rows);
        cfg_shift = 5'(shift);
        cfg_interleave = inter;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_rows = c_CNT_W'($urandom);
        cfg_shift = 5'($urandom);
        cfg_interleave = ~inter;
        check("busy_after_start", c_W'(busy), c_W'(1));
        check("sat_cleared_on_start", c_W'(sat_flag), c_W'(0));
        if (eff == 0) begin
            check("done_empty_job", c_W'(done), c_W'(1));
            check("ready_empty_job", c_W'(bus.in_ready), c_W'(0));
            @(posedge clk); #1;
            check("done_end_empty_job", c_W'(done), c_W'(0));
            check("idle_empty_job", c_W'(busy), c_W'(0));
            check("writes_empty_job", c_W'(job_writes), c_W'(0));
            return;
        end
        acc = 0;
        cyc = 0;
        stray_done = 1'b0;
        while (acc < eff && cyc < eff * 20 + 100) begin
            v = ($urandom_range(99) < vpct);
            row = v ? gen_row(mode, acc) : gen_row(1, acc);
            bus.in_valid = v;
            bus.in_data = row;
            if (!stray_done && acc == stray_at) begin
                start = 1'b1;
                cfg_rows = 10'd3;
                stray_done = 1'b1;
            end
            check("in_ready_run", c_W'(bus.in_ready), c_W'(1));
            if (v) begin
                model_row(row, shift, d, clamp);
                m_sat |= clamp;
                sb_q.push_back('{bank: inter ? acc % c_NB : acc / c_DEPTH,
                                 addr: inter ? acc / c_NB : acc % c_DEPTH, data: d});
                acc++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (acc == abort_after) begin
                bus.in_valid = 1'b1;
                srst = 1'b1;
                @(posedge clk); #1;
                srst = 1'b0;
                check("abort_enable", c_W'(bus.sram_write_enable), c_W'(0));
                check("abort_busy", c_W'(busy), c_W'(0));
                check("abort_ready", c_W'(bus.in_ready), c_W'(0));
                check("abort_sat", c_W'(sat_flag), c_W'(0));
                check("abort_pending_rows", c_W'(sb_q.size()), c_W'(0));
                bus.in_valid = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    check("abort_no_done", c_W'(done), c_W'(0));
                end
                sb_q.delete();
                return;
            end
        end
        check("rows_accepted", c_W'(acc), c_W'(eff));
        bus.in_valid = 1'b1;
        bus.in_data = gen_row(1, 0);
        check("ready_low_flush", c_W'(bus.in_ready), c_W'(0));
        check("done_flush", c_W'(done), c_W'(0));
        check("busy_flush", c_W'(busy), c_W'(1));
        @(posedge clk); #1;
        check("done_pulse", c_W'(done), c_W'(1));
        check("ready_low_done", c_W'(bus.in_ready), c_W'(0));
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        check("done_single_cycle", c_W'(done), c_W'(0));
        check("busy_cleared", c_W'(busy), c_W'(0));
        check("sat_flag", c_W'(sat_flag), c_W'(m_sat));
        check("write_count", c_W'(job_writes), c_W'(eff));
        check("distinct_locations", c_W'(hit_count()), c_W'(eff));
        check("scoreboard_drained", c_W'(sb_q.size()), c_W'(0));
    endtask

    initial begin : watchdog
        #2000000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;
        check("reset_busy", c_W'(busy), c_W'(0));
        check("reset_done", c_W'(done), c_W'(0));
        check("reset_sat", c_W'(sat_flag), c_W'(0));
        check("reset_ready", c_W'(bus.in_ready), c_W'(0));
        check("reset_enable", c_W'(bus.sram_write_enable), c_W'(0));
        check("reset_wdata", bus.sram_wdata, c_W'(0));
        check("reset_waddr", c_W'(bus.sram_waddr), c_W'(0));

        // Valid rows offered while idle must be refused.
        bus.in_valid = 1'b1;
        bus.in_data = gen_row(1, 0);
        repeat (2) begin
            check("idle_ready", c_W'(bus.in_ready), c_W'(0));
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;

        run_job(70, 0, 1'b0, 100, 0, -1, -1);
        run_job(7, 0, 1'b1, 100, 0, -1, -1);
        run_job(2, 4, 1'b0, 100, 2, -1, -1);
        run_job(5, 0, 1'b1, 100, 3, -1, -1);
        run_job(200, int'($urandom_range(0, 31)), 1'b1, 60, 1, -1, -1);
        run_job(0, 3, 1'b0, 100, 1, -1, -1);
        run_job(12, 2, 1'b0, 80, 1, -1, 5);
        run_job(20, 3, 1'b0, 100, 1, 10, -1);
        run_job(6, 0, 1'b0, 100, 0, -1, -1);
        for (int j = 0; j < 6; j++) begin
            run_job(int'($urandom_range(1, 40)), int'($urandom_range(0, 31)),
                    $urandom_range(0, 1) == 1, int'($urandom_range(30, 100)),
                    ($urandom_range(0, 1) == 1) ? 1 : 3, -1, -1);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tpu_wb_ctrl.md
Name: tpu_wb_ctrl

Overview:
Parametrised result write-back controller for the systolic TPU. It accepts one row of per-lane accumulator results from the array each cycle through a valid/ready handshake, then rescales and saturates each lane. It packs the lanes into an output-SRAM word and writes that word into one of NUM_BANKS output SRAM banks, in either bank-sequential or bank-interleaved order. It replaces fixed three-bank write-back (a/b/c banks, 8 lanes x 16 bit, 6-bit address) with a generalised bank, width and depth scheme.

Parameters:
LANES, 8, array columns (lanes per output word)
ACC_W, 24, signed accumulator width per lane at input
DATA_W, 16, signed stored width per lane; word width = LANES*DATA_W
NUM_BANKS, 3, number of output SRAM banks
ADDR_W, 6, per-bank address width (depth 2^ADDR_W)
CNT_W, 10, width of row count; must satisfy 2^CNT_W > NUM_BANKS*2^ADDR_W

Ports:
clk  in  1  clock, rising edge
srst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; launches a job when idle
cfg_rows  in  CNT_W  rows to write for this job; sampled on accepted start
cfg_shift  in  5  arithmetic right shift applied per lane; sampled on start
cfg_interleave  in  1  0 = bank-sequential, 1 = bank-interleaved; sampled on start
in_valid  in  1  row result valid
in_ready  out  1  controller accepts a row this cycle
in_data  in  LANES*ACC_W  lane i in bits [i*ACC_W +: ACC_W]
sram_write_enable  out  NUM_BANKS  one-hot write strobe per bank, active-high
sram_wdata  out  LANES*DATA_W  packed word; lane i in bits [i*DATA_W +: DATA_W]
sram_waddr  out  ADDR_W  address shared by all banks
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
sat_flag  out  1  sticky: some lane saturated during the current job

Behaviour:
- Reset (srst=1 at an edge) clears all outputs and internal counters to 0; state becomes IDLE. This applies mid-job: the job is aborted, no further write is issued, and no done pulse is produced.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - start=1 samples cfg_*, clears sat_flag and the row/bank/address counters, and goes to RUN.
  - Effective rows = min(cfg_rows, NUM_BANKS*2^ADDR_W); the excess is silently dropped.
  - If effective rows = 0, go straight to DONE.
- RUN:
  - in_ready = 1 while accepted rows < effective rows; a row is accepted on in_valid & in_ready.
  - Accepting the last row moves the FSM to FLUSH.
  - start is ignored outside IDLE.
- Write latency is 1 cycle. A row accepted at edge t appears at edge t+1 as sram_wdata/sram_waddr, with exactly one sram_write_enable bit high for that cycle.
  - With no acceptance, the enable is all-zero; wdata/waddr hold their last value.
- FLUSH: the final write is issued; go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- busy = 1 in RUN, FLUSH and DONE.
- Ordering uses bank and address counters only (no dividers):
  - Sequential: addr increments per row; on reaching 2^ADDR_W-1 it wraps to 0 and bank increments. Row r goes to bank r / 2^ADDR_W, address r mod 2^ADDR_W.
  - Interleaved: bank increments per row; on reaching NUM_BANKS-1 it wraps to 0 and addr increments. Row r goes to bank r mod NUM_BANKS, address r / NUM_BANKS.
- Lane arithmetic (combinational before the output register):
  - s = cfg_shift; when s > 0, round half up by adding 2^(s-1) before the arithmetic right shift. Use ACC_W+1 bit intermediates so there is no overflow.
  - Saturate the result to signed DATA_W: max 2^(DATA_W-1)-1, min -2^(DATA_W-1).
  - Any clamped lane on an accepted row sets sat_flag. sat_flag holds until the next accepted start or reset.
  - cfg_shift >= ACC_W yields 0 for non-negative inputs and -1 for negative inputs, before rounding.
- No other output changes when in_valid=1 while in_ready=0.

Test Plan:
- Sequential, rows=70, shift=0, lane i of row r = r*8+i: bank0 addr 0..63 gets rows 0..63, bank1 addr 0..5 gets rows 64..69; bank2 is never written; exactly 70 enables; done one cycle after the last write.
- Interleaved, rows=7: banks 0,1,2,0,1,2,0 at addrs 0,0,0,1,1,1,2; wdata matches input rows with 1-cycle latency.
- Saturation/rounding, shift=4, lanes {0x00_0018, 0x7F_FFFF, 0xFF_FFF7, 0x80_0000}: outputs {0x0002, 0x7FFF, 0xFFFF, 0x8000}; sat_flag=1 after the row; a new start clears it.
- Backpressure: random in_valid gaps and rows=200 (clamped to 192): exactly 192 writes, all 64 addresses in all 3 banks; in_ready=0 after row 192; done pulses once.
- rows=0: done one cycle after start with no write; a start pulsed during RUN is ignored with no counter change.
- srst asserted after 10 of 20 rows: next cycle enables=0, busy=0, done never pulses; a fresh start restarts at bank0 addr0.
